// File: rtl/fp_wb_scheduler.sv
// -----------------------------------------------------------------------------
// fp_wb_scheduler
//
// Grants or withholds issue on the two FP issue ports so that granted uops
// never oversubscribe the FP writeback ports and never collide in the
// unpipelined divide/sqrt unit. A reservation table res[0..DIV_LAT] counts the
// writebacks already booked k cycles from now; it shifts down by one entry
// every cycle, and each grant books its slot at res[L-1] of the next cycle.
//
// Ports
//   clock      : single clock, rising edge
//   reset      : synchronous, active-low; clears the table and divider counter
//   flush      : forces gnt to 0 this cycle, clears all state on the next edge
//   req_valid  : issue request per port (port 0 has priority)
//   req_class  : uop class per port (00 FMA, 01 MISC, 10 DIV/SQRT, 11 illegal)
//   gnt        : combinational grant per port, same cycle as the request
//   div_busy   : divider occupied, DIV requests cannot be granted
//   wb_due     : number of results writing back in the current cycle
// -----------------------------------------------------------------------------
module fp_wb_scheduler #(
    parameter int FMA_LAT  = 4,
    parameter int MISC_LAT = 2,
    parameter int DIV_LAT  = 12,
    parameter int WB_PORTS = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic [1:0]      req_valid,
    input  logic [1:0][1:0] req_class,
    output logic [1:0]      gnt,
    output logic            div_busy,
    output logic [1:0]      wb_due
);

    localparam int CNT_W = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;
    localparam int IDX_W = $clog2(DIV_LAT + 1);
    localparam logic [2:0] WB_LIM = 3'(WB_PORTS);

    typedef enum logic [1:0] {
        CLS_FMA  = 2'b00,
        CLS_MISC = 2'b01,
        CLS_DIV  = 2'b10,
        CLS_ILL  = 2'b11
    } uop_class_e;

    typedef logic [IDX_W-1:0] lat_t;

    function automatic lat_t class_lat(input logic [1:0] cls);
        case (uop_class_e'(cls))
            CLS_FMA:  return lat_t'(FMA_LAT);
            CLS_MISC: return lat_t'(MISC_LAT);
            CLS_DIV:  return lat_t'(DIV_LAT);
            default:  return lat_t'(0);
        endcase
    endfunction

    logic [1:0]       res_q [DIV_LAT+1];
    logic [1:0]       res_d [DIV_LAT+1];
    logic [CNT_W-1:0] div_cnt_q;
    logic [CNT_W-1:0] div_cnt_d;

    lat_t       lat0, lat1;
    logic       legal0, legal1;
    logic       is_div0, is_div1;
    logic       div_free;
    logic       grant0, grant1;
    logic [2:0] occ0, occ1;

    // ---------------------------------------------------------------------
    // Grant logic. Port 1 sees port 0's same-cycle grant both in the bucket
    // occupancy and in divider arbitration; nothing feeds gnt back into itself.
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        grant0   = 1'b0;
        grant1   = 1'b0;
        lat0     = class_lat(req_class[0]);
        lat1     = class_lat(req_class[1]);
        legal0   = uop_class_e'(req_class[0]) != CLS_ILL;
        legal1   = uop_class_e'(req_class[1]) != CLS_ILL;
        is_div0  = uop_class_e'(req_class[0]) == CLS_DIV;
        is_div1  = uop_class_e'(req_class[1]) == CLS_DIV;
        div_free = (div_cnt_q == '0);

        occ0 = {1'b0, res_q[lat0]};
        if (req_valid[0] && legal0 && !flush && (occ0 < WB_LIM)
            && (!is_div0 || div_free)) begin
            grant0 = 1'b1;
        end

        occ1 = {1'b0, res_q[lat1]} + ((grant0 && (lat0 == lat1)) ? 3'd1 : 3'd0);
        if (req_valid[1] && legal1 && !flush && (occ1 < WB_LIM)
            && (!is_div1 || (div_free && !(grant0 && is_div0)))) begin
            grant1 = 1'b1;
        end
    end

    assign gnt      = {grant1, grant0};
    assign wb_due   = res_q[0];
    assign div_busy = (div_cnt_q != '0);

    // ---------------------------------------------------------------------
    // Next state: shift the table down one slot and book this cycle's grants
    // one slot short of their latency, since the shift happens on the same edge.
    // ---------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < DIV_LAT; k++) begin
            res_d[k] = res_q[k+1]
                     + ((grant0 && (lat0 == lat_t'(k + 1))) ? 2'd1 : 2'd0)
                     + ((grant1 && (lat1 == lat_t'(k + 1))) ? 2'd1 : 2'd0);
        end
        res_d[DIV_LAT] = '0;

        div_cnt_d = div_cnt_q;
        if ((grant0 && is_div0) || (grant1 && is_div1)) begin
            div_cnt_d = CNT_W'(DIV_LAT - 1);
        end else if (div_cnt_q != '0) begin
            div_cnt_d = div_cnt_q - 1'b1;
        end

        if (flush) begin
            for (int k = 0; k <= DIV_LAT; k++) begin
                res_d[k] = '0;
            end
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            // NOTE: the table is a handful of flops rather than a RAM, so it is
            // cleared element by element on reset like any other state.
            for (int k = 0; k <= DIV_LAT; k++) begin
                res_q[k] <= '0;
            end
            div_cnt_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            res_q     <= res_d;
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: doc/fp_wb_scheduler.md
# fp_wb_scheduler

The FP writeback scheduler sits between the FP issue queue and the FP execution units. Each cycle it grants or withholds issue for the two FP issue ports. It tracks writeback-port reservations for the fixed-latency pipelines and occupancy of the unpipelined divide/sqrt unit, so that granted uops never oversubscribe the FP writeback ports and never collide in the divider. It also reports how many results are due on writeback each cycle, and drops all in-flight state on a pipeline flush.

## Interface
- `FMA_LAT`, default 4: FMA pipeline latency in cycles, issue to writeback (≥1).
- `MISC_LAT`, default 2: latency of compare/move/convert/sign-inject ops (≥1).
- `DIV_LAT`, default 12: divide/sqrt latency; must be ≥ `FMA_LAT` and ≥ `MISC_LAT`.
- `WB_PORTS`, default 2: FP writeback ports available per cycle (1..3).
- `clock`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-low reset.
- `flush`, in, 1: pipeline flush; kills in-flight reservations.
- `req_valid`, in, 2: issue request, one bit per FP issue port; port 0 has priority.
- `req_class`, in, 2×2: uop class per port:
  - 2'b00 FMA
  - 2'b01 MISC
  - 2'b10 DIV/SQRT
  - 2'b11 illegal, never granted
- `gnt`, out, 2: combinational grant per port, same cycle as `req_valid`.
- `div_busy`, out, 1: divider occupied; a DIV request cannot be granted.
- `wb_due`, out, 2: number of results scheduled to write back in the current cycle.

## Operation
- **Reservation table:** `res[0..DIV_LAT]`, each entry 2 bits. `res[k]` holds the writebacks reserved k cycles from now.
- **Latency mapping:** a uop's class maps to L = `FMA_LAT`, `MISC_LAT` or `DIV_LAT`.
- **Port 0 grant:** `req_valid[0]` and class legal and `res[L0] < WB_PORTS` and not `flush`. For DIV, `div_cnt == 0` is also required.
- **Port 1 grant:** same rule, with two additions:
  - The bucket occupancy counts port 0's same-cycle grant: `res[L1] + (gnt[0] && L0==L1) < WB_PORTS`.
  - A DIV request on port 1 is denied if port 0 is granted a DIV in the same cycle.
- **Table update each cycle:**
  - `res'[k] = res[k+1] + (number of grants with L == k+1)` for k = 0..DIV_LAT-1.
  - `res'[DIV_LAT] = 0`.
  - `wb_due = res[0]`.
- **Divider counter:** `div_cnt` is ceil(log2(DIV_LAT)) bits wide.
  - On a DIV grant it loads `DIV_LAT-1`.
  - Otherwise it decrements while nonzero.
  - `div_busy = (div_cnt != 0)`.
- **Flush:** `gnt` is forced to 0 in the flush cycle. On the next edge, all `res` entries and `div_cnt` clear.
- **Illegal class:** a request with class 11 is never granted and does not block the other port.
- **Request/grant handshake:** an ungranted request is simply re-presented by the issue queue; the scheduler keeps no request state.

## Timing
- **Reset:** `reset` low at an edge zeroes all `res` entries and `div_cnt`. The outputs after that edge are `gnt=0` when `req_valid=0`, `div_busy=0` and `wb_due=0`.
- **Reset mid-operation:** pending reservations and divider occupancy are discarded. `wb_due` reads 0 in the first cycle after reset.
- **Grant timing:** a grant in cycle t produces a `wb_due` contribution exactly in cycle t+L.
- **Back-to-back divides:** a DIV granted in cycle t holds `div_busy=1` for cycles t+1 .. t+DIV_LAT-1. The next DIV can be granted in cycle t+DIV_LAT.
- **Bucket limit:** `wb_due` never exceeds `WB_PORTS`; a grant that would overflow a bucket is withheld.
- **Flush and reset together:** reset has priority; the result is identical in either case.
- **`gnt` path:** purely combinational from `req_valid`, `req_class`, `flush` and registered state. There is no path from `gnt` back into itself.

## Test plan
1. **Reset and idle:** hold `reset=0` for 2 cycles, then release with no requests. Required: `gnt=00`, `div_busy=0`, `wb_due=0` on every cycle.
2. **Double FMA:** cycle 0, both ports request FMA. Required:
   - cycle 0: `gnt=11`;
   - cycle 4: `wb_due=2`;
   - cycles 1–3 and 5: `wb_due=0`.
3. **Latency collision:** cycle 0, two FMA granted; cycle 2, port 0 requests MISC (L=2 lands in the full bucket at cycle 4). Required:
   - cycle 2: `gnt[0]=0`;
   - cycle 3: the same request is granted, with `wb_due=1` at cycle 5.
4. **Divider serialization:**
   - cycle 0: both ports request DIV. Required: `gnt=01`.
   - cycle 1: the request is re-presented. Required: `gnt[0]=0`, `div_busy=1`; `div_busy` stays high through cycle 11.
   - cycle 12: DIV is granted again.
   - Required throughout: `wb_due=1` at cycle 12 and again at cycle 24.
5. **Flush mid-flight:** cycle 0, DIV granted; cycle 1, FMA granted; cycle 3, `flush=1` with both ports requesting. Required:
   - cycle 3: `gnt=00`;
   - cycle 4: `div_busy=0`;
   - `wb_due=0` at cycles 5 and 12;
   - a DIV is grantable again at cycle 4.
6. **Illegal class and priority:** port 0 class 11 with port 1 FMA. Required: `gnt=10` (port 1 only). Then both ports MISC with `WB_PORTS=1`. Required: `gnt=01` (port 0 only).
